pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit; the registered successor to the combinational ripple full_adder.
- Splits a WIDTH-bit operation into STAGES carry-chained slices, with one slice per clock stage and the carry registered between stages.
- Uses valid/ready handshakes on both sides and stalls the whole pipeline on backpressure.
- Feeds the coefficient/accumulate datapaths where a full-width ripple chain misses timing.

Parameters:
WIDTH, `W_COE (8), operand and result width in bits; must be divisible by STAGES.
STAGES, 2, pipeline depth and slice count; 1..WIDTH; slice width CW = WIDTH/STAGES.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit accepts beat this cycle
a  input  WIDTH  operand A (two's complement or unsigned)
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (subtract: 1 = no borrow)
ovf  output  1  signed overflow

Behaviour:
- Reset (async assert, released synchronously by clock use): every stage valid bit = 0, every data/carry register = 0.
  - Outputs during reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Operand preparation at input:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? 1 : cin; cin is ignored when sub=1.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b_eff (bits k*CW+CW-1 : k*CW) plus the carry from stage k-1; stage 0 uses c_eff.
  - Registers the slice sum and the carry-out.
- Skew alignment:
  - Unconsumed upper slices of a/b_eff travel down the pipeline with the beat.
  - Completed lower-slice sums travel with the beat, so the final stage presents a fully aligned result.
- Final stage produces:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid, with no back-pressure.
- Throughput: one beat per cycle.
- Flow control:
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - When stall=1, all stage registers and valid bits hold.
  - When stall=0, every stage advances; stage 0 valid loads in_valid.
  - Bubbles (valid=0 stages) propagate and are not compressed.
- Output behaviour:
  - sum, cout and ovf are held stable while out_valid && !out_ready.
  - Data registers update only on advance; output values when out_valid=0 are don't-care.
- Boundary conditions:
  - in_valid with in_ready=0: beat is not accepted; upstream must hold it.
  - Simultaneous out_ready rising and new in_valid: both transfers occur in the same cycle, with no lost or duplicated beat.
  - STAGES=1: single registered full-width adder, latency 1.
  - STAGES=WIDTH: 1-bit slices, latency WIDTH.
  - Reset mid-operation: all in-flight beats are discarded immediately and out_valid drops asynchronously; nothing is emitted after release until a new accepted beat has traversed STAGES cycles.
- Illegal parameters (WIDTH % STAGES != 0, STAGES < 1) are rejected at elaboration.

Test Plan (WIDTH=8, STAGES=2 unless noted):
1. a=0xFF, b=0x01, cin=0, sub=0, one beat, out_ready=1 -> out_valid at cycle +2: sum=0x00, cout=1, ovf=0 (carry crosses the slice boundary).
2. a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1; then a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0 (cin ignored).
3. 16 random back-to-back beats, out_ready=1 -> 16 results on consecutive cycles, matching a reference model in order; in_ready stays 1.
4. Fill the pipe, drop out_ready for 5 cycles -> in_ready=0 after out_valid; sum/cout/ovf are stable all 5 cycles; no loss or duplication after out_ready returns.
5. Assert rst with 2 beats in flight -> out_valid=0 immediately; after release, no output until a new beat has been accepted and 2 cycles have elapsed.
6. STAGES=1 and STAGES=8 builds, a=0x80, b=0x80, sub=0 -> sum=0x00, cout=1, ovf=1 at latency 1 and 8 respectively.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES carry-chained slices,
// one slice per stage, with a valid/ready handshake and full-pipeline stall.
`ifndef W_COE
`define W_COE 8
`endif

module pipe_adder_stage #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s,
  input  logic             ci,
  output logic [WIDTH-1:0] aq,
  output logic [WIDTH-1:0] bq,
  output logic [WIDTH-1:0] sq,
  output logic             cq
);
  localparam int LO = K * CW;

  logic [CW:0]      slc;
  logic [WIDTH-1:0] s_nxt;

  always_comb begin
    slc = {1'b0, a[LO +: CW]} + {1'b0, b[LO +: CW]} + {{CW{1'b0}}, ci};
    s_nxt = s;
    s_nxt[LO +: CW] = slc[CW-1:0];
  end

  // operands travel whole so later slices and the final overflow test see them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq <= '0;
      bq <= '0;
      sq <= '0;
      cq <= 1'b0;
    end else if (adv) begin
      aq <= a;
      bq <= b;
      sq <= s_nxt;
      cq <= slc[CW];
    end
  end
endmodule

module pipe_adder #(
  parameter int WIDTH  = `W_COE,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad
      $error("pipe_adder: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  localparam int CW = WIDTH / STAGES;

  logic                        adv;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][WIDTH-1:0]  a_p, b_p, s_p;
  logic [STAGES:0]             c_p;
  logic                        unused;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  assign vld_pipe[0] = in_valid;
  assign a_p[0]      = a;
  assign b_p[0]      = sub ? ~b : b;
  assign s_p[0]      = '0;
  assign c_p[0]      = sub | cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_pipe[STAGES:1] <= '0;
    else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      pipe_adder_stage #(.WIDTH(WIDTH), .CW(CW), .K(k)) u_stg (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .a   (a_p[k]),
        .b   (b_p[k]),
        .s   (s_p[k]),
        .ci  (c_p[k]),
        .aq  (a_p[k+1]),
        .bq  (b_p[k+1]),
        .sq  (s_p[k+1]),
        .cq  (c_p[k+1])
      );
    end
  endgenerate

  assign out_valid = vld_pipe[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = (a_p[STAGES][WIDTH-1] == b_p[STAGES][WIDTH-1]) &&
                     (s_p[STAGES][WIDTH-1] != a_p[STAGES][WIDTH-1]);

  // only the MSBs of the last stage's operand copies feed the overflow test
  assign unused = ^{a_p[STAGES], b_p[STAGES]};
endmodule
